// File: rtl/debport_pkg.sv
// Shared constants for the debug input port: register map and edge-select codes.
package debport_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD    = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/debport_in_capture_if.sv
// Avalon-MM slave bus plus interrupt line of the debug input port.
interface debport_in_capture_if;
    import debport_pkg::*;

    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [BUS_W-1:0] writedata;
    logic [BUS_W-1:0] readdata;
    logic             irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/debport_in_debounce.sv
// One-bit debouncer: the output follows the input only after it has differed
// for DEBOUNCE_CYCLES consecutive clocks.
module debport_in_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive disagreeing cycles; restart on any agreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (raw == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            level <= raw;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/debport_in_capture.sv
// Debug input port: synchronizes in_port, latches per-bit edges into a
// write-1-to-clear capture register and raises a maskable level irq.
// Optional per-bit debounce stage: define DEBPORT_IN_DEBOUNCE_EN.
module debport_in_capture
    import debport_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned RESET_MASK      = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    debport_in_capture_if.slave   bus,
    input  logic [DATA_WIDTH-1:0] in_port
);
    logic [DATA_WIDTH-1:0] sync1;
    logic [DATA_WIDTH-1:0] sync2;
    logic [DATA_WIDTH-1:0] level;
    logic [DATA_WIDTH-1:0] prev;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] clr;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecap;
    logic                  wr_en;

    // Upper write-data bits are intentionally ignored.
    wire unused_wd = &{1'b0, bus.writedata};

    // Two-flop synchronizer plus previous-level register for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= level;
        end
    end

`ifdef DEBPORT_IN_DEBOUNCE_EN
    for (genvar i = 0; i < int'(DATA_WIDTH); i++) begin : g_deb
        debport_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (sync2[i]),
            .level (level[i])
        );
    end
`else
    assign level = sync2;
`endif

    // Edge selection by EDGE_TYPE.
    always_comb begin
        edge_det = level & ~prev;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_det = ~level & prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_det = level ^ prev;
        end
    end

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign clr   = (wr_en && bus.address == ADDR_EDGECAP) ?
                   bus.writedata[DATA_WIDTH-1:0] : '0;

    // Mask register and sticky capture; a same-cycle set beats the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask <= DATA_WIDTH'(RESET_MASK);
            edgecap <= '0;
        end else begin
            if (wr_en && bus.address == ADDR_IRQMASK) begin
                irqmask <= bus.writedata[DATA_WIDTH-1:0];
            end
            edgecap <= (edgecap & ~clr) | edge_det;
        end
    end

    // Zero-wait-state read mux, zero-extended.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata = BUS_W'(level);
            ADDR_IRQMASK: bus.readdata = BUS_W'(irqmask);
            ADDR_EDGECAP: bus.readdata = BUS_W'(edgecap);
            default:      bus.readdata = '0;
        endcase
    end

    assign bus.irq = |(edgecap & irqmask);
endmodule

// File: tb/tb_debport_in_capture.sv
// Directed bench for debport_in_capture: one instance with rising-edge capture
// and zero reset mask, one with any-edge capture and reset mask 0x01.
module tb_debport_in_capture;
    import debport_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in0;
    logic [7:0] in2;
    int         checks = 0;
    int         errors = 0;

    debport_in_capture_if bus0 ();
    debport_in_capture_if bus2 ();

    debport_in_capture #(
        .DATA_WIDTH(8), .EDGE_TYPE(0), .RESET_MASK(0), .DEBOUNCE_CYCLES(16)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .in_port(in0)
    );

    debport_in_capture #(
        .DATA_WIDTH(8), .EDGE_TYPE(2), .RESET_MASK(1), .DEBOUNCE_CYCLES(16)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .in_port(in2)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int d, input logic [1:0] a, input logic [31:0] exp, input string tag);
        if (d == 0) bus0.address = a;
        else        bus2.address = a;
        #1;
        chk(tag, (d == 0) ? bus0.readdata : bus2.readdata, exp);
    endtask

    task automatic irq_chk(input int d, input logic exp, input string tag);
        chk(tag, {31'd0, (d == 0) ? bus0.irq : bus2.irq}, {31'd0, exp});
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
        if (d == 0) begin
            bus0.address = a; bus0.writedata = v; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        end else begin
            bus2.address = a; bus2.writedata = v; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
        end
        tick();
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        in0 = 8'h00;
        in2 = 8'h00;
        bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
        bus2.address = 2'd0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
        tick(2);
        reset = 1'b0;
        tick();

        // Post-reset register map
        rd(0, ADDR_DATA,    32'h0, "rst_data");
        rd(0, ADDR_IRQMASK, 32'h0, "rst_mask");
        rd(0, ADDR_RSVD,    32'h0, "rst_rsvd");
        rd(0, ADDR_EDGECAP, 32'h0, "rst_cap");
        irq_chk(0, 1'b0, "rst_irq");
        rd(2, ADDR_IRQMASK, 32'h1, "rst_mask2");

`ifdef DEBPORT_IN_DEBOUNCE_EN
        // Short pulse is filtered out
        in0 = 8'h08;
        tick(10);
        in0 = 8'h00;
        tick(25);
        rd(0, ADDR_EDGECAP, 32'h0, "deb_short_cap");
        rd(0, ADDR_DATA,    32'h0, "deb_short_data");
        // Long pulse: capture 16+3 edges after the input rises
        in0 = 8'h08;
        tick(18);
        rd(0, ADDR_DATA,    32'h08, "deb_long_data");
        rd(0, ADDR_EDGECAP, 32'h0,  "deb_long_early");
        tick();
        rd(0, ADDR_EDGECAP, 32'h08, "deb_long_cap");
`else
        // Rising edges: DATA after 2 edges, EDGECAP after 3, irq masked off
        in0 = 8'hA5;
        tick();
        rd(0, ADDR_DATA,    32'h00, "lat_data1");
        tick();
        rd(0, ADDR_DATA,    32'hA5, "lat_data2");
        rd(0, ADDR_EDGECAP, 32'h00, "lat_cap2");
        tick();
        rd(0, ADDR_EDGECAP, 32'hA5, "lat_cap3");
        irq_chk(0, 1'b0, "irq_masked");

        // Mask in bit 0, then W1C it
        wr(0, ADDR_IRQMASK, 32'h01);
        irq_chk(0, 1'b1, "irq_on");
        rd(0, ADDR_IRQMASK, 32'h01, "mask_rd");
        wr(0, ADDR_EDGECAP, 32'h01);
        rd(0, ADDR_EDGECAP, 32'hA4, "w1c");
        irq_chk(0, 1'b0, "irq_off");

        // Upper writedata bits, reserved and DATA writes are ignored
        wr(0, ADDR_IRQMASK, 32'hFFFF_FF00);
        rd(0, ADDR_IRQMASK, 32'h00, "mask_hi_bits");
        wr(0, ADDR_RSVD, 32'hFF);
        rd(0, ADDR_RSVD, 32'h00, "rsvd_wr");
        wr(0, ADDR_DATA, 32'h00);
        rd(0, ADDR_DATA, 32'hA5, "data_wr");

        // Falling edge ignored in rise mode; set beats same-cycle clear
        wr(0, ADDR_EDGECAP, 32'hFF);
        rd(0, ADDR_EDGECAP, 32'h00, "clr_all");
        in0 = 8'hA1;
        tick(3);
        rd(0, ADDR_EDGECAP, 32'h00, "fall_ignored");
        in0 = 8'hA5;
        tick(2);
        wr(0, ADDR_EDGECAP, 32'h04);
        rd(0, ADDR_EDGECAP, 32'h04, "set_wins");
        wr(0, ADDR_IRQMASK, 32'h04);
        irq_chk(0, 1'b1, "irq_bit2");

        // Any-edge mode: each toggle of bit 0 captured, with 4-cycle spacing
        in2 = 8'h01;
        tick(3);
        rd(2, ADDR_EDGECAP, 32'h01, "any_rise1");
        irq_chk(2, 1'b1, "any_irq");
        wr(2, ADDR_EDGECAP, 32'h01);
        rd(2, ADDR_EDGECAP, 32'h00, "any_clr1");
        in2 = 8'h00;
        tick(3);
        rd(2, ADDR_EDGECAP, 32'h01, "any_fall");
        wr(2, ADDR_EDGECAP, 32'h01);
        rd(2, ADDR_EDGECAP, 32'h00, "any_clr2");
        in2 = 8'h01;
        tick(3);
        rd(2, ADDR_EDGECAP, 32'h01, "any_rise2");
        wr(2, ADDR_EDGECAP, 32'h01);
        tick(2);
        rd(2, ADDR_EDGECAP, 32'h00, "pre_glitch");
        // One-cycle low glitch
        in2 = 8'h00;
        tick();
        in2 = 8'h01;
        tick(2);
        rd(2, ADDR_EDGECAP, 32'h01, "glitch_cap");

        // Reset mid-operation, with in_port held high across release
        reset = 1'b1;
        tick();
        rd(0, ADDR_EDGECAP, 32'h00, "mid_rst_cap");
        rd(0, ADDR_IRQMASK, 32'h00, "mid_rst_mask");
        rd(0, ADDR_DATA,    32'h00, "mid_rst_data");
        irq_chk(0, 1'b0, "mid_rst_irq");
        reset = 1'b0;
        tick(2);
        rd(0, ADDR_DATA,    32'hA5, "rel_data");
        rd(0, ADDR_EDGECAP, 32'h00, "rel_cap_early");
        tick();
        rd(0, ADDR_EDGECAP, 32'hA5, "rel_cap");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
